fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. Holds the PC and issues word requests to instruction memory over a valid/ready request channel with a valid-only response channel. Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake. Supports a redirect (branch/jump target) that flushes buffered and in-flight fetches.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_1000;

  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem request/response, redirect, and decode handshake.
interface fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch queue; flush wins over push/pop, no read bypass.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, redirect squash,
// and a small queue toward decode.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC,
  parameter int              FQ_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  import fetch_stage_pkg::*;

  localparam int CW = $clog2(FQ_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q;
  logic            accept, rsp_wait, rsp_any, redir;
  entry_t          push_entry, head;
  logic [CW-1:0]   fq_count;
  logic            fq_full, fq_empty;

  assign redir    = bus.redirect_valid;
  assign rsp_any  = bus.imem_rsp_valid;
  assign rsp_wait = (state_q == WAIT) && rsp_any;

  assign bus.imem_req_valid = (state_q == ISSUE) && (fq_count < CW'(FQ_DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      BOOT:  state_d = ISSUE;
      ISSUE: if (accept) begin
               state_d = WAIT;
               pc_d    = pc_q + XLEN'(4);
             end
      WAIT:  if (rsp_any) state_d = ISSUE;
      DRAIN: if (rsp_any) state_d = ISSUE;
      default: state_d = BOOT;
    endcase
    // A redirect overrides everything; anything still in flight must be drained.
    if (redir) begin
      pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      unique case (state_q)
        ISSUE:       state_d = accept  ? DRAIN : ISSUE;
        WAIT, DRAIN: state_d = rsp_any ? ISSUE : DRAIN;
        default:     state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (accept) req_pc_q <= pc_q;
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: bus.imem_rsp_data};

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_wait && !redir && !fq_full),
    .push_data (push_entry),
    .pop       (bus.if_valid && bus.if_ready),
    .flush     (redir),
    .head      (head),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign bus.if_valid = !fq_empty;
  assign bus.if_instr = head.instr;
  assign bus.if_pc    = head.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;

  fetch_stage_if #(.XLEN(32), .ILEN(32)) bus();

  fetch_stage #(
    .XLEN(32), .ILEN(32), .RESET_PC(32'h0000_1000), .FQ_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  ent_t        mq[$];     // expected queue contents toward decode
  ent_t        got[$];    // what the DUT actually handed to decode
  logic [31:0] acc[$];    // accepted request addresses
  logic [31:0] words[$];  // preset memory data, else random
  int          total = 0, bad = 0;
  bit          outst, squashed, spurious_en;
  logic [31:0] out_addr, exp_pc, p_ra;
  bit          p_rv, p_rr, p_redir;
  int          mem_wait, mem_lat, cyc, acc_cyc, iv_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check DUT outputs against the model, then apply this cycle's events.
  task automatic observe();
    logic rv, rr, sv, iv, ir, rd;
    logic [31:0] ra, rpc;
    ent_t e;
    cyc++;
    if (rst) begin
      p_rv = 0; p_rr = 0; p_redir = 0;
      return;
    end
    rv = bus.imem_req_valid; rr = bus.imem_req_ready; ra = bus.imem_req_addr;
    sv = bus.imem_rsp_valid; iv = bus.if_valid;        ir = bus.if_ready;
    rd = bus.redirect_valid; rpc = bus.redirect_pc;

    chk("if_valid", iv, mq.size() != 0);
    if (iv === 1'b1 && mq.size() != 0) begin
      chk("if_pc", bus.if_pc, mq[0].pc);
      chk("if_instr", bus.if_instr, mq[0].instr);
    end
    if (rv === 1'b1) begin
      chk("req_one_outstanding", outst, 0);
      chk("req_addr", ra, exp_pc);
    end
    if (p_rv && !p_rr && !p_redir) begin
      chk("req_valid_hold", rv, 1);
      chk("req_addr_hold", ra, p_ra);
    end

    if (iv && ir && mq.size() != 0) begin
      e.pc = bus.if_pc; e.instr = bus.if_instr;
      got.push_back(e);
      void'(mq.pop_front());
    end
    if (iv && iv_cyc < 0) iv_cyc = cyc;
    if (sv && outst) begin
      if (!squashed && !rd) begin
        e.pc = out_addr; e.instr = bus.imem_rsp_data;
        mq.push_back(e);
      end
      outst = 0;
    end
    if (rv && rr) begin
      outst = 1; squashed = rd; out_addr = ra; exp_pc = ra + 32'd4;
      acc.push_back(ra); mem_wait = mem_lat - 1;
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (rd) begin
      mq.delete();
      if (outst) squashed = 1;
      exp_pc = {rpc[31:2], 2'b00};
    end
    p_rv = rv; p_rr = rr; p_redir = rd; p_ra = ra;
  endtask

  task automatic drive_mem();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (outst) begin
      if (mem_wait <= 0) begin
        bus.imem_rsp_valid = 1'b1;
        if (words.size() != 0) bus.imem_rsp_data = words.pop_front();
      end else mem_wait--;
    end else if (spurious_en && $urandom_range(0, 19) == 0) begin
      bus.imem_rsp_valid = 1'b1;
    end
  endtask

  task automatic sample();  @(negedge clk); observe(); endtask
  task automatic advance(); @(posedge clk); #1; drive_mem(); endtask
  task automatic tick();    sample(); advance(); endtask

  task automatic wait_acc(input string tag);
    int start = acc.size();
    int k = 0;
    while (acc.size() <= start && k < 50) begin tick(); k++; end
    chk(tag, acc.size() > start, 1);
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 60) begin tick(); k++; end
    chk(tag, got.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.if_ready = 0;
    mq.delete(); got.delete(); acc.delete(); words.delete();
    outst = 0; squashed = 0; exp_pc = 32'h1000; mem_wait = 0; mem_lat = 1;
    spurious_en = 0; acc_cyc = -1; iv_cyc = -1;
    repeat (2) begin
      sample();
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_if_valid", bus.if_valid, 0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h1000);
      chk("rst_if_instr", bus.if_instr, 0);
      chk("rst_if_pc", bus.if_pc, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cyc = 0;

    // Boot: one idle cycle, then a request at RESET_PC.
    do_reset();
    bus.imem_req_ready = 1; bus.if_ready = 1;
    sample(); chk("boot_req_valid", bus.imem_req_valid, 0); advance();
    sample(); chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_req_addr", bus.imem_req_addr, 32'h1000); advance();

    // In-order delivery with 1-cycle memory.
    do_reset();
    bus.imem_req_ready = 1; bus.if_ready = 1;
    words.push_back(32'h00A00093); words.push_back(32'h00B00113); words.push_back(32'h002081B3);
    wait_got(3, "stream_timeout");
    chk("stream_pc0", got[0].pc, 32'h1000); chk("stream_in0", got[0].instr, 32'h00A00093);
    chk("stream_pc1", got[1].pc, 32'h1004); chk("stream_in1", got[1].instr, 32'h00B00113);
    chk("stream_pc2", got[2].pc, 32'h1008); chk("stream_in2", got[2].instr, 32'h002081B3);
    chk("latency", iv_cyc - acc_cyc, 2);

    // Decode stalled: queue fills, requests stop, then resume at 0x1008.
    do_reset();
    bus.imem_req_ready = 1; bus.if_ready = 0;
    repeat (10) tick();
    sample();
    chk("full_if_valid", bus.if_valid, 1);
    chk("full_if_pc", bus.if_pc, 32'h1000);
    chk("full_no_req", bus.imem_req_valid, 0);
    chk("full_acc_count", acc.size(), 2);
    advance();
    bus.if_ready = 1;
    wait_acc("resume_timeout");
    chk("resume_addr", acc[acc.size()-1], 32'h1008);
    chk("drained_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("drained_pc0", got[0].pc, 32'h1000);
      chk("drained_pc1", got[1].pc, 32'h1004);
    end

    // Memory back-pressure: request held stable.
    do_reset();
    bus.imem_req_ready = 0; bus.if_ready = 1;
    tick();
    repeat (3) begin
      sample();
      chk("bp_req_valid", bus.imem_req_valid, 1);
      chk("bp_req_addr", bus.imem_req_addr, 32'h1000);
      advance();
    end
    chk("bp_no_accept", acc.size(), 0);
    bus.imem_req_ready = 1;
    wait_acc("bp_acc_timeout");
    wait_acc("bp_next_timeout");
    chk("bp_next_addr", acc[acc.size()-1], 32'h1004);

    // Redirect in WAIT, late response is dropped.
    do_reset();
    bus.imem_req_ready = 1; bus.if_ready = 1; mem_lat = 3;
    wait_acc("rw_acc_timeout");
    mem_lat = 1;
    bus.redirect_valid = 1; bus.redirect_pc = 32'h2003;
    tick();
    bus.redirect_valid = 0;
    sample();
    chk("rw_drain_no_req", bus.imem_req_valid, 0);
    chk("rw_queue_empty", bus.if_valid, 0);
    advance();
    wait_got(1, "rw_got_timeout");
    chk("rw_first_pc", got[0].pc, 32'h2000);
    chk("rw_req_addr", acc[1], 32'h2000);

    // Redirect with a response and a pop in the same cycle.
    do_reset();
    bus.imem_req_ready = 1; bus.if_ready = 0;
    wait_acc("rr_acc0_timeout");
    wait_acc("rr_acc1_timeout");
    bus.redirect_valid = 1; bus.redirect_pc = 32'h3000; bus.if_ready = 1;
    sample();
    chk("rr_head_valid", bus.if_valid, 1);
    chk("rr_head_pc", bus.if_pc, 32'h1000);
    chk("rr_rsp_present", bus.imem_rsp_valid, 1);
    advance();
    bus.redirect_valid = 0;
    sample();
    chk("rr_queue_empty", bus.if_valid, 0);
    chk("rr_req_valid", bus.imem_req_valid, 1);
    chk("rr_req_addr", bus.imem_req_addr, 32'h3000);
    advance();
    chk("rr_delivered", got.size(), 1);

    // Randomized traffic, including redirects near the top of the address space.
    do_reset();
    spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom_range(0, 9) < 7);
      bus.if_ready       = ($urandom_range(0, 9) < 6);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                       : $urandom;
      mem_lat = $urandom_range(1, 3);
      tick();
    end
    bus.redirect_valid = 0; bus.if_ready = 1; bus.imem_req_ready = 1; spurious_en = 0;
    repeat (12) tick();
    chk("rand_progress", got.size() > 200, 1);
    chk("rand_drained", bus.if_valid, mq.size() != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
